// File: rtl/dic_time_dpath.sv
// -----------------------------------------------------------------------------
// dic_time_dpath
// Time-keeping datapath of the digital clock. Sits behind the clock control
// FSM: takes its run / per-digit load / per-digit display / alarm-enable
// strobes plus the decoded UART digit, keeps the MM:SS time and alarm
// registers, counts seconds, rings the alarm and drives registered,
// per-digit-blanked BCD digits to the display driver.
//
// Parameters:
//   CLK_PER_SEC    clk cycles per one-second tick
//   ALARM_RING_SEC ticks alarm_ring stays high after a match
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   dicRun                        time counting enabled
//   dicLd{Mtens,Mones,Stens,Sones}   load ld_digit into a time digit
//   alarmLd{Mtens,Mones,Stens,Sones} load ld_digit into an alarm digit
//   dicDsp{...} / alarmDsp{...}   per-digit visibility of time / alarm
//   alarm_en                      alarm armed
//   ld_digit[3:0]                 binary digit from the UART decoder
//   disp_mt/mo/st/so[3:0]         displayed BCD digits (registered)
//   disp_blank[3:0]               {mt,mo,st,so}, 1 = blank (registered)
//   tick_1s                       one-cycle pulse per second (registered)
//   alarm_ring                    alarm active (registered)
//
// Optional feature (compile-time macro ALARM_BLINK_EN): while ringing with
// the time source selected, all digits blank on alternate ticks.
// -----------------------------------------------------------------------------
module dic_time_dpath #(
  parameter int CLK_PER_SEC    = 12000000,
  parameter int ALARM_RING_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dicRun,
  input  logic       dicLdMtens,
  input  logic       dicLdMones,
  input  logic       dicLdStens,
  input  logic       dicLdSones,
  input  logic       alarmLdMtens,
  input  logic       alarmLdMones,
  input  logic       alarmLdStens,
  input  logic       alarmLdSones,
  input  logic       dicDspMtens,
  input  logic       dicDspMones,
  input  logic       dicDspStens,
  input  logic       dicDspSones,
  input  logic       alarmDspMtens,
  input  logic       alarmDspMones,
  input  logic       alarmDspStens,
  input  logic       alarmDspSones,
  input  logic       alarm_en,
  input  logic [3:0] ld_digit,
  output logic [3:0] disp_mt,
  output logic [3:0] disp_mo,
  output logic [3:0] disp_st,
  output logic [3:0] disp_so,
  output logic [3:0] disp_blank,
  output logic       tick_1s,
  output logic       alarm_ring
);

  localparam int PSC_W  = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int RING_W = (ALARM_RING_SEC > 1) ? $clog2(ALARM_RING_SEC) : 1;
  localparam logic [PSC_W-1:0]  PSC_LAST  = PSC_W'(CLK_PER_SEC - 1);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(ALARM_RING_SEC - 1);

  typedef enum logic {IDLE = 1'b0, RING = 1'b1} alarmState_t;

  // Tens digits hold 0..5, ones digits 0..9; out-of-range loads clamp.
  function automatic logic [3:0] satTens(input logic [3:0] d);
    satTens = (d > 4'd5) ? 4'd5 : d;
  endfunction

  function automatic logic [3:0] satOnes(input logic [3:0] d);
    satOnes = (d > 4'd9) ? 4'd9 : d;
  endfunction

  logic [PSC_W-1:0]  prescCnt_r;
  logic [RING_W-1:0] ringCnt_r;
  alarmState_t       alarmState_r;
  logic [3:0]        mtens_r, mones_r, stens_r, sones_r;
  logic [3:0]        alarmMt_r, alarmMo_r, alarmSt_r, alarmSo_r;
  logic [3:0]        incMt_s, incMo_s, incSt_s, incSo_s;
  logic              anyDicLd_s, anyAlarmDsp_s, tick_s, match_s, blinkForce_s;

  assign anyDicLd_s    = dicLdMtens | dicLdMones | dicLdStens | dicLdSones;
  assign anyAlarmDsp_s = alarmDspMtens | alarmDspMones | alarmDspStens | alarmDspSones;
  // A load cycle never produces a tick, so loads can't trigger the alarm.
  assign tick_s        = dicRun & ~anyDicLd_s & (prescCnt_r == PSC_LAST);
  assign match_s       = alarm_en & tick_s &
                         ({incMt_s, incMo_s, incSt_s, incSo_s} ==
                          {alarmMt_r, alarmMo_r, alarmSt_r, alarmSo_r});

  // Prescaler and registered one-second pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescCnt_r <= {PSC_W{1'b0}};
      tick_1s    <= 1'b0;
    end else begin
      tick_1s <= tick_s;
      if (anyDicLd_s) begin
        prescCnt_r <= {PSC_W{1'b0}};
      end else if (dicRun) begin
        prescCnt_r <= (prescCnt_r == PSC_LAST) ? {PSC_W{1'b0}} : prescCnt_r + PSC_W'(1);
      end else begin
        prescCnt_r <= prescCnt_r;
      end
    end
  end

  // Next time value for a one-second increment, BCD carries and 59:59 wrap.
  always_comb begin
    incMt_s = mtens_r;
    incMo_s = mones_r;
    incSt_s = stens_r;
    incSo_s = 4'd0;
    if (sones_r == 4'd9) begin
      incSo_s = 4'd0;
      if (stens_r == 4'd5) begin
        incSt_s = 4'd0;
        if (mones_r == 4'd9) begin
          incMo_s = 4'd0;
          if (mtens_r == 4'd5) begin
            incMt_s = 4'd0;
          end else begin
            incMt_s = mtens_r + 4'd1;
          end
        end else begin
          incMo_s = mones_r + 4'd1;
        end
      end else begin
        incSt_s = stens_r + 4'd1;
      end
    end else begin
      incSo_s = sones_r + 4'd1;
    end
  end

  // Time registers: per-digit load wins, otherwise advance on the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtens_r <= 4'd0;
      mones_r <= 4'd0;
      stens_r <= 4'd0;
      sones_r <= 4'd0;
    end else if (anyDicLd_s) begin
      mtens_r <= dicLdMtens ? satTens(ld_digit) : mtens_r;
      mones_r <= dicLdMones ? satOnes(ld_digit) : mones_r;
      stens_r <= dicLdStens ? satTens(ld_digit) : stens_r;
      sones_r <= dicLdSones ? satOnes(ld_digit) : sones_r;
    end else if (tick_s) begin
      mtens_r <= incMt_s;
      mones_r <= incMo_s;
      stens_r <= incSt_s;
      sones_r <= incSo_s;
    end else begin
      mtens_r <= mtens_r;
      mones_r <= mones_r;
      stens_r <= stens_r;
      sones_r <= sones_r;
    end
  end

  // Alarm registers: load only, never count.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarmMt_r <= 4'd0;
      alarmMo_r <= 4'd0;
      alarmSt_r <= 4'd0;
      alarmSo_r <= 4'd0;
    end else begin
      alarmMt_r <= alarmLdMtens ? satTens(ld_digit) : alarmMt_r;
      alarmMo_r <= alarmLdMones ? satOnes(ld_digit) : alarmMo_r;
      alarmSt_r <= alarmLdStens ? satTens(ld_digit) : alarmSt_r;
      alarmSo_r <= alarmLdSones ? satOnes(ld_digit) : alarmSo_r;
    end
  end

  // Alarm FSM: ring for ALARM_RING_SEC ticks after a match, disarm drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarmState_r <= IDLE;
      ringCnt_r    <= {RING_W{1'b0}};
      alarm_ring   <= 1'b0;
    end else begin
      case (alarmState_r)
        IDLE: begin
          if (match_s) begin
            alarmState_r <= RING;
            ringCnt_r    <= {RING_W{1'b0}};
            alarm_ring   <= 1'b1;
          end else begin
            alarmState_r <= IDLE;
            ringCnt_r    <= ringCnt_r;
            alarm_ring   <= 1'b0;
          end
        end
        RING: begin
          if (!alarm_en) begin
            alarmState_r <= IDLE;
            ringCnt_r    <= ringCnt_r;
            alarm_ring   <= 1'b0;
          end else if (match_s) begin
            alarmState_r <= RING;
            ringCnt_r    <= {RING_W{1'b0}};
            alarm_ring   <= 1'b1;
          end else if (tick_s && (ringCnt_r == RING_LAST)) begin
            alarmState_r <= IDLE;
            ringCnt_r    <= ringCnt_r;
            alarm_ring   <= 1'b0;
          end else if (tick_s) begin
            alarmState_r <= RING;
            ringCnt_r    <= ringCnt_r + RING_W'(1);
            alarm_ring   <= 1'b1;
          end else begin
            alarmState_r <= RING;
            ringCnt_r    <= ringCnt_r;
            alarm_ring   <= 1'b1;
          end
        end
        default: begin
          alarmState_r <= IDLE;
          ringCnt_r    <= {RING_W{1'b0}};
          alarm_ring   <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALARM_BLINK_EN
  logic blinkPhase_r;

  // Blink phase: visible on ring entry, flips on every tick while ringing.
  always_ff @(posedge clk) begin
    if (rst) begin
      blinkPhase_r <= 1'b0;
    end else if ((alarmState_r == IDLE) && match_s) begin
      blinkPhase_r <= 1'b0;
    end else if ((alarmState_r == RING) && tick_s) begin
      blinkPhase_r <= ~blinkPhase_r;
    end else begin
      blinkPhase_r <= blinkPhase_r;
    end
  end

  assign blinkForce_s = alarm_ring & blinkPhase_r;
`else
  assign blinkForce_s = 1'b0;
`endif

  // Display register: alarm source if any alarm digit is visible, else time.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_mt    <= 4'd0;
      disp_mo    <= 4'd0;
      disp_st    <= 4'd0;
      disp_so    <= 4'd0;
      disp_blank <= 4'b1111;
    end else if (anyAlarmDsp_s) begin
      disp_mt    <= alarmMt_r;
      disp_mo    <= alarmMo_r;
      disp_st    <= alarmSt_r;
      disp_so    <= alarmSo_r;
      disp_blank <= ~{alarmDspMtens, alarmDspMones, alarmDspStens, alarmDspSones};
    end else begin
      disp_mt    <= mtens_r;
      disp_mo    <= mones_r;
      disp_st    <= stens_r;
      disp_so    <= sones_r;
      disp_blank <= blinkForce_s ? 4'b1111
                                 : ~{dicDspMtens, dicDspMones, dicDspStens, dicDspSones};
    end
  end

endmodule

// File: tb/tb_dic_time_dpath.sv
`timescale 1ns/1ps
module tb_dic_time_dpath;
  localparam int CPS = 4;
  localparam int RS  = 3;

  logic clk = 1'b0;
  logic rst, dicRun, alarm_en;
  logic [3:0] dLd, aLd, dDsp, aDsp, ldDigit;
  logic [3:0] disp_mt, disp_mo, disp_st, disp_so, disp_blank;
  logic tick_1s, alarm_ring;
  logic [15:0] dispV;
  int errors = 0;
  int checks = 0;

  // Reference model state: time as total seconds, alarm as digits [3]=mt..[0]=so
  int mPsc, mSecs, mLeft;
  int mAl[4];
  bit mRing, mPhase;
  logic eTick, eRing;
  logic [15:0] eDisp;
  logic [3:0] eBlank;

  assign dispV = {disp_mt, disp_mo, disp_st, disp_so};

  always #5 clk = ~clk;

  dic_time_dpath #(.CLK_PER_SEC(CPS), .ALARM_RING_SEC(RS)) dut (
    .clk(clk), .rst(rst), .dicRun(dicRun),
    .dicLdMtens(dLd[3]), .dicLdMones(dLd[2]), .dicLdStens(dLd[1]), .dicLdSones(dLd[0]),
    .alarmLdMtens(aLd[3]), .alarmLdMones(aLd[2]), .alarmLdStens(aLd[1]), .alarmLdSones(aLd[0]),
    .dicDspMtens(dDsp[3]), .dicDspMones(dDsp[2]), .dicDspStens(dDsp[1]), .dicDspSones(dDsp[0]),
    .alarmDspMtens(aDsp[3]), .alarmDspMones(aDsp[2]), .alarmDspStens(aDsp[1]), .alarmDspSones(aDsp[0]),
    .alarm_en(alarm_en), .ld_digit(ldDigit),
    .disp_mt(disp_mt), .disp_mo(disp_mo), .disp_st(disp_st), .disp_so(disp_so),
    .disp_blank(disp_blank), .tick_1s(tick_1s), .alarm_ring(alarm_ring)
  );

  function automatic int satDigit(int idx, int v);
    int lim;
    lim = (idx % 2 == 1) ? 5 : 9;
    return (v > lim) ? lim : v;
  endfunction

  function automatic int digitOf(int secs, int idx);
    case (idx)
      3: return secs / 600;
      2: return (secs / 60) % 10;
      1: return (secs % 60) / 10;
      default: return secs % 10;
    endcase
  endfunction

  // Advance model and DUT by one clock with the currently driven inputs.
  task automatic step();
    int d[4];
    int nSecs, aSecs;
    bit anyLd, anyA, tick, match;
    if (rst) begin
      mPsc = 0; mSecs = 0; mLeft = 0; mRing = 0; mPhase = 0;
      for (int i = 0; i < 4; i++) mAl[i] = 0;
      eTick = 1'b0; eRing = 1'b0; eDisp = 16'h0; eBlank = 4'hF;
    end else begin
      anyA = |aDsp;
      for (int i = 0; i < 4; i++) begin
        d[i] = digitOf(mSecs, i);
        eDisp[i*4 +: 4] = anyA ? 4'(mAl[i]) : 4'(d[i]);
      end
      eBlank = anyA ? ~aDsp : ~dDsp;
`ifdef ALARM_BLINK_EN
      if (mRing && !anyA && mPhase) eBlank = 4'hF;
`endif
      anyLd = |dLd;
      tick = dicRun && !anyLd && (mPsc == CPS - 1);
      if (anyLd) mPsc = 0;
      else if (dicRun) mPsc = (mPsc + 1) % CPS;
      if (anyLd) begin
        for (int i = 0; i < 4; i++) if (dLd[i]) d[i] = satDigit(i, int'(ldDigit));
        nSecs = d[3] * 600 + d[2] * 60 + d[1] * 10 + d[0];
      end else if (tick) nSecs = (mSecs + 1) % 3600;
      else nSecs = mSecs;
      aSecs = mAl[3] * 600 + mAl[2] * 60 + mAl[1] * 10 + mAl[0];
      match = alarm_en && tick && (nSecs == aSecs);
      if (!mRing && match) mPhase = 0;
      else if (mRing && tick) mPhase = !mPhase;
      if (!mRing) begin
        if (match) begin mRing = 1; mLeft = RS; end
      end else if (!alarm_en) mRing = 0;
      else if (match) mLeft = RS;
      else if (tick) begin
        mLeft = mLeft - 1;
        if (mLeft == 0) mRing = 0;
      end
      for (int i = 0; i < 4; i++) if (aLd[i]) mAl[i] = satDigit(i, int'(ldDigit));
      mSecs = nSecs;
      eTick = tick;
      eRing = mRing;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dicRun = 1'b0; alarm_en = 1'b0;
    dLd = 4'h0; aLd = 4'h0; dDsp = 4'h0; aDsp = 4'h0; ldDigit = 4'h0;
    step(); step();
    rst = 1'b0;
    checks++; if (dispV !== 16'h0) begin errors++; $display("FAIL reset_disp: got %h expected 0000", dispV); end
    checks++; if (disp_blank !== 4'hF) begin errors++; $display("FAIL reset_blank: got %b expected 1111", disp_blank); end
    checks++; if (tick_1s !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick_1s); end
    checks++; if (alarm_ring !== 1'b0) begin errors++; $display("FAIL reset_ring: got %b expected 0", alarm_ring); end
  endtask

  task automatic test_count();
    int nTicks, lastTick;
    nTicks = 0; lastTick = -1;
    dicRun = 1'b1; dDsp = 4'hF;
    for (int c = 0; c < 60 * CPS; c++) begin
      step();
      checks++; if (tick_1s !== eTick) begin errors++; $display("FAIL count_tick: cycle %0d got %b expected %b", c, tick_1s, eTick); end
      if (tick_1s === 1'b1) begin
        if (lastTick >= 0) begin
          checks++; if (c - lastTick != CPS) begin errors++; $display("FAIL tick_period: got %0d expected %0d", c - lastTick, CPS); end
        end
        lastTick = c;
        nTicks++;
      end
    end
    checks++; if (nTicks != 60) begin errors++; $display("FAIL tick_count: got %0d expected 60", nTicks); end
    dicRun = 1'b0;
    step();
    checks++; if (dispV !== 16'h0100) begin errors++; $display("FAIL count_disp: got %h expected 0100", dispV); end
    checks++; if (disp_blank !== 4'h0) begin errors++; $display("FAIL count_blank: got %b expected 0000", disp_blank); end
  endtask

  task automatic test_load_sat();
    dicRun = 1'b0;
    dLd = 4'b1000; ldDigit = 4'd8; step(); dLd = 4'h0; step();
    checks++; if (disp_mt !== 4'd5) begin errors++; $display("FAIL sat_tens: got %0d expected 5", disp_mt); end
    dLd = 4'b0100; ldDigit = 4'd12; step(); dLd = 4'h0; step();
    checks++; if (disp_mo !== 4'd9) begin errors++; $display("FAIL sat_ones: got %0d expected 9", disp_mo); end
    dLd = 4'b1000; ldDigit = 4'd5; step();
    dLd = 4'b0100; ldDigit = 4'd9; step();
    dLd = 4'b0010; ldDigit = 4'd5; step();
    dLd = 4'b0001; ldDigit = 4'd9; step();
    dLd = 4'h0; step();
    checks++; if (dispV !== 16'h5959) begin errors++; $display("FAIL load_5959: got %h expected 5959", dispV); end
    dicRun = 1'b1;
    for (int c = 0; c < CPS; c++) begin
      step();
      checks++; if (tick_1s !== ((c == CPS - 1) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL wrap_tick: cycle %0d got %b", c, tick_1s); end
    end
    step();
    checks++; if (dispV !== 16'h0000) begin errors++; $display("FAIL wrap_disp: got %h expected 0000", dispV); end
  endtask

  task automatic test_load_tick();
    int guard;
    guard = 0;
    dicRun = 1'b1;
    while (mPsc != CPS - 1 && guard < 2 * CPS) begin step(); guard++; end
    checks++; if (mPsc != CPS - 1) begin errors++; $display("FAIL align_timeout: got %0d expected %0d", mPsc, CPS - 1); end
    dLd = 4'b0001; ldDigit = 4'd7; step(); dLd = 4'h0;
    checks++; if (tick_1s !== 1'b0) begin errors++; $display("FAIL ld_tick_suppress: got %b expected 0", tick_1s); end
    step();
    checks++; if (disp_so !== 4'd7) begin errors++; $display("FAIL ld_over_tick: got %0d expected 7", disp_so); end
    step(); step(); step();
    checks++; if (tick_1s !== 1'b1) begin errors++; $display("FAIL ld_next_tick: got %b expected 1", tick_1s); end
    step();
    checks++; if (disp_so !== 4'd8) begin errors++; $display("FAIL ld_then_inc: got %0d expected 8", disp_so); end
  endtask

  task automatic test_alarm();
    int nTicks, riseAt, fallAt;
    nTicks = 0; riseAt = -1; fallAt = -1;
    dicRun = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    aLd = 4'b0001; ldDigit = 4'd3; step(); aLd = 4'h0;
    alarm_en = 1'b1; dicRun = 1'b1; dDsp = 4'hF;
    for (int c = 0; c < 10 * CPS; c++) begin
      step();
      if (tick_1s === 1'b1) nTicks++;
      checks++; if (alarm_ring !== eRing) begin errors++; $display("FAIL ring_model: cycle %0d got %b expected %b", c, alarm_ring, eRing); end
      if (alarm_ring === 1'b1 && riseAt < 0) begin
        riseAt = nTicks;
        checks++; if (tick_1s !== 1'b1) begin errors++; $display("FAIL ring_rise_tick: got %b expected 1", tick_1s); end
      end
      if (alarm_ring === 1'b0 && riseAt >= 0 && fallAt < 0) fallAt = nTicks;
    end
    checks++; if (riseAt != 3) begin errors++; $display("FAIL ring_rise: got tick %0d expected 3", riseAt); end
    checks++; if (fallAt != 6) begin errors++; $display("FAIL ring_fall: got tick %0d expected 6", fallAt); end
  endtask

  task automatic test_alarm_drop();
    bit found;
    dicRun = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    aLd = 4'b0001; ldDigit = 4'd2; step(); aLd = 4'h0;
    alarm_en = 1'b1; dicRun = 1'b1;
    found = 0;
    for (int c = 0; c < 5 * CPS && !found; c++) begin step(); if (alarm_ring === 1'b1) found = 1; end
    checks++; if (!found) begin errors++; $display("FAIL drop_ring_timeout: got 0 expected 1"); end
    alarm_en = 1'b0; step();
    checks++; if (alarm_ring !== 1'b0) begin errors++; $display("FAIL drop_ring: got %b expected 0", alarm_ring); end
    alarm_en = 1'b1; dLd = 4'b0001; ldDigit = 4'd0; step(); dLd = 4'h0;
    found = 0;
    for (int c = 0; c < 5 * CPS && !found; c++) begin step(); if (alarm_ring === 1'b1) found = 1; end
    checks++; if (!found) begin errors++; $display("FAIL rering_timeout: got 0 expected 1"); end
    rst = 1'b1; dLd = 4'hF; aLd = 4'hF; ldDigit = 4'd9; step();
    checks++; if ({dispV, disp_blank, tick_1s, alarm_ring} !== {16'h0, 4'hF, 2'b00})
      begin errors++; $display("FAIL rst_mid_ring: got %h/%b/%b/%b expected 0000/1111/0/0", dispV, disp_blank, tick_1s, alarm_ring); end
    rst = 1'b0; dLd = 4'h0; aLd = 4'h0; step();
    checks++; if (dispV !== 16'h0) begin errors++; $display("FAIL rst_mid_load: got %h expected 0000", dispV); end
  endtask

  task automatic test_alarm_dsp();
    rst = 1'b1; step(); rst = 1'b0;
    dicRun = 1'b0; alarm_en = 1'b0; dDsp = 4'hF;
    dLd = 4'b1000; ldDigit = 4'd1; step();
    dLd = 4'b0100; ldDigit = 4'd2; step();
    dLd = 4'b0010; ldDigit = 4'd3; step();
    dLd = 4'b0001; ldDigit = 4'd4; step();
    dLd = 4'h0;
    aLd = 4'b1000; ldDigit = 4'd4; step();
    aLd = 4'b0100; ldDigit = 4'd5; step();
    aLd = 4'h0; aDsp = 4'b1100;
    for (int c = 0; c < 20; c++) step();
    checks++; if (dispV !== 16'h4500) begin errors++; $display("FAIL alarm_src_disp: got %h expected 4500", dispV); end
    checks++; if (disp_blank !== 4'b0011) begin errors++; $display("FAIL alarm_src_blank: got %b expected 0011", disp_blank); end
    aDsp = 4'h0; step();
    checks++; if (dispV !== 16'h1234) begin errors++; $display("FAIL time_held: got %h expected 1234", dispV); end
    checks++; if (disp_blank !== 4'b0000) begin errors++; $display("FAIL time_src_blank: got %b expected 0000", disp_blank); end
  endtask

  task automatic test_random();
    rst = 1'b1; step(); rst = 1'b0;
    aLd = 4'b0001; ldDigit = 4'd5; step(); aLd = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 499) == 0);
      dicRun   = ($urandom_range(0, 7) != 0);
      dLd      = ($urandom_range(0, 99) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      aLd      = ($urandom_range(0, 99) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      ldDigit  = 4'($urandom_range(0, 15));
      dDsp     = 4'($urandom_range(0, 15));
      aDsp     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      alarm_en = ($urandom_range(0, 15) != 0);
      step();
      checks++; if (dispV !== eDisp) begin errors++; $display("FAIL rnd_disp: cycle %0d got %h expected %h", c, dispV, eDisp); end
      checks++; if (disp_blank !== eBlank) begin errors++; $display("FAIL rnd_blank: cycle %0d got %b expected %b", c, disp_blank, eBlank); end
      checks++; if (tick_1s !== eTick) begin errors++; $display("FAIL rnd_tick: cycle %0d got %b expected %b", c, tick_1s, eTick); end
      checks++; if (alarm_ring !== eRing) begin errors++; $display("FAIL rnd_ring: cycle %0d got %b expected %b", c, alarm_ring, eRing); end
    end
    rst = 1'b0; dLd = 4'h0; aLd = 4'h0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_load_sat();
    test_load_tick();
    test_alarm();
    test_alarm_drop();
    test_alarm_dsp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
